// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write tracker: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard #(
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          set,
  input  logic [AW-1:0] set_idx,
  input  logic          clr,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          mask1,
  input  logic          mask2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREG-1:0] pend_reg;
  logic [NREG-1:0] pend_next;

  // Register 0 can never be pending; set takes priority over clear.
  assign pend_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_pend
      logic set_hit;
      logic clr_hit;
      assign set_hit = en && set && (set_idx == AW'(gi));
      assign clr_hit = en && clr && (clr_idx == AW'(gi));
      assign pend_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : pend_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  assign busy1 = en && pend_reg[rs1] && !mask1;
  assign busy2 = en && pend_reg[rs2] && !mask2;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with power-on zero sweep, optional
// write forwarding and a pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREG   = DEF_NREG,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            we,
  input  logic [XLEN-1:0] rwdata,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  output logic [XLEN-1:0] xlast,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            ready
);

  state_t          state_reg;
  logic [AW-1:0]   idx_reg;
  logic [XLEN-1:0] mem [NREG];

  logic            run;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      idx_reg   <= '0;
    end else if (state_reg == CLEAR) begin
      idx_reg <= idx_reg + 1'b1;
      if (idx_reg == AW'(NREG - 1)) begin
        state_reg <= RUN;
      end
    end
  end

  // rst masks everything combinationally so outputs drop before the reset edge.
  assign run      = (state_reg == RUN) && !rst;
  assign ready    = run;
  assign wr_valid = run && we && (rd != '0);

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rd;
    wr_data = rwdata;
    if (!rst && state_reg == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = idx_reg;
      wr_data = '0;
    end else if (wr_valid) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  logic [AW-1:0]   rs_a  [2];
  logic [XLEN-1:0] rv_a  [2];
  logic            hit_a [2];

  assign rs_a[0] = rs1;
  assign rs_a[1] = rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      assign hit_a[gi] = (BYPASS != 0) && wr_valid && (rd == rs_a[gi]);
      assign rv_a[gi]  = (!run || rs_a[gi] == '0) ? '0 :
                         (hit_a[gi] ? rwdata : mem[rs_a[gi]]);
    end
  endgenerate

  assign rv1   = rv_a[0];
  assign rv2   = rv_a[1];
  assign xlast = run ? mem[NREG-1] : '0;

  regfile_scoreboard #(
    .NREG(NREG)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .set    (busy_set),
    .set_idx(busy_rd),
    .clr    (we && (rd != '0)),
    .clr_idx(rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .mask1  (hit_a[0]),
    .mask2  (hit_a[1]),
    .busy1  (busy1),
    .busy2  (busy2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two DUTs (forwarding on/off) against an array-based model.
module tb_regfile_sb;

  localparam int NREG = 32;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, busy_rd = '0;
  logic        we = 1'b0, busy_set = 1'b0;
  logic [31:0] rwdata = '0;

  logic [31:0] rv1_b, rv2_b, xlast_b, rv1_n, rv2_n, xlast_n;
  logic        busy1_b, busy2_b, ready_b, busy1_n, busy2_n, ready_n;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we), .rwdata(rwdata),
    .rv1(rv1_b), .rv2(rv2_b), .xlast(xlast_b), .busy_set(busy_set), .busy_rd(busy_rd),
    .busy1(busy1_b), .busy2(busy2_b), .ready(ready_b)
  );

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we), .rwdata(rwdata),
    .rv1(rv1_n), .rv2(rv2_n), .xlast(xlast_n), .busy_set(busy_set), .busy_rd(busy_rd),
    .busy1(busy1_n), .busy2(busy2_n), .ready(ready_n)
  );

  typedef struct packed {
    logic        ready;
    logic [31:0] rv1_b, rv2_b, rv1_n, rv2_n, xlast;
    logic        busy1_b, busy2_b, busy1_n, busy2_n;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Reference model: register values, pending flags, edges since reset.
  logic [31:0] m_reg [NREG];
  bit          m_pend [NREG];
  int          m_cnt = 0;

  function automatic logic [31:0] m_rv(bit run, bit byp, bit w, logic [4:0] wa,
                                       logic [31:0] d, logic [4:0] a);
    if (!run || a == 0) return 32'h0;
    if (byp && w && wa != 0 && wa == a) return d;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(bit run, bit byp, bit w, logic [4:0] wa, logic [4:0] a);
    if (!run || a == 0) return 1'b0;
    if (byp && w && wa != 0 && wa == a) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic step(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input bit bs, input logic [4:0] ba);
    exp_t e;
    bit run;
    @(posedge clk);
    #1;
    rst = r; we = w; rd = wa; rwdata = d; rs1 = a1; rs2 = a2; busy_set = bs; busy_rd = ba;
    run = !r && (m_cnt >= NREG);
    e.ready   = run;
    e.rv1_b   = m_rv(run, 1, w, wa, d, a1);
    e.rv2_b   = m_rv(run, 1, w, wa, d, a2);
    e.rv1_n   = m_rv(run, 0, w, wa, d, a1);
    e.rv2_n   = m_rv(run, 0, w, wa, d, a2);
    e.xlast   = run ? m_reg[NREG-1] : 32'h0;
    e.busy1_b = m_busy(run, 1, w, wa, a1);
    e.busy2_b = m_busy(run, 1, w, wa, a2);
    e.busy1_n = m_busy(run, 0, w, wa, a1);
    e.busy2_n = m_busy(run, 0, w, wa, a2);
    q.push_back(e);
    // Effect of the upcoming edge.
    if (r) begin
      m_cnt = 0;
      for (int i = 0; i < NREG; i++) m_pend[i] = 0;
    end else if (m_cnt < NREG) begin
      m_cnt++;
      if (m_cnt == NREG) for (int i = 0; i < NREG; i++) m_reg[i] = 32'h0;
    end else begin
      if (w && wa != 0) begin
        m_reg[wa]  = d;
        m_pend[wa] = 0;
      end
      if (bs && ba != 0) m_pend[ba] = 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s txn=%0d actual=%h required=%h", name, n_txn, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_txn++;
        chk("ready_b", {31'h0, ready_b}, {31'h0, e.ready});
        chk("ready_n", {31'h0, ready_n}, {31'h0, e.ready});
        chk("rv1_b", rv1_b, e.rv1_b);
        chk("rv2_b", rv2_b, e.rv2_b);
        chk("rv1_n", rv1_n, e.rv1_n);
        chk("rv2_n", rv2_n, e.rv2_n);
        chk("xlast_b", xlast_b, e.xlast);
        chk("xlast_n", xlast_n, e.xlast);
        chk("busy1_b", {31'h0, busy1_b}, {31'h0, e.busy1_b});
        chk("busy2_b", {31'h0, busy2_b}, {31'h0, e.busy2_b});
        chk("busy1_n", {31'h0, busy1_n}, {31'h0, e.busy1_n});
        chk("busy2_n", {31'h0, busy2_n}, {31'h0, e.busy2_n});
        $display("txn %0d rst=%0d we=%0d rd=%0d rs1=%0d rs2=%0d rv1_b=%h rv1_n=%h rdy=%0d",
                 n_txn, rst, we, rd, rs1, rs2, rv1_b, rv1_n, ready_b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] a1, a2, wa, ba;
    for (int i = 0; i < NREG; i++) begin
      m_reg[i] = 32'h0;
      m_pend[i] = 0;
    end
    // Reset pulse and sweep; writes during the sweep must be ignored.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NREG; i++) step(0, (i % 3) == 0, 5'd3, 32'hFF, 5'd3, 5'd31, i[0], 5'd3);
    for (int i = 0; i < NREG; i++) step(0, 0, 0, 0, 5'(i), 5'(NREG - 1 - i), 0, 0);
    // Forwarding on a fresh write.
    step(0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd4, 0, 0);
    step(0, 0, 0, 0, 5'd5, 5'd5, 0, 0);
    // Writes to x0 are dropped.
    step(0, 1, 5'd0, 32'h1234, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 1, 5'd0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 0, 0);
    // Set-wins-over-clear on x7.
    step(0, 0, 0, 0, 5'd7, 5'd0, 1, 5'd7);
    step(0, 1, 5'd7, 32'h77, 5'd7, 5'd6, 1, 5'd7);
    step(0, 0, 0, 0, 5'd7, 5'd7, 0, 0);
    step(0, 1, 5'd7, 32'h78, 5'd7, 5'd7, 0, 0);
    step(0, 0, 0, 0, 5'd7, 5'd7, 0, 0);
    // Reset in the middle of a sweep restarts it.
    step(0, 1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd0, 1, 5'd31);
    step(0, 0, 0, 0, 5'd31, 5'd31, 0, 0);
    step(1, 0, 0, 0, 5'd31, 5'd31, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 5'd31, 5'd31, 0, 0);
    step(1, 1, 5'd31, 32'h1, 5'd31, 5'd31, 0, 0);
    for (int i = 0; i < NREG + 3; i++) step(0, 0, 0, 0, 5'd31, 5'(i), 0, 0);
    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      wa = 5'($urandom_range(0, NREG - 1));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, NREG - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, NREG - 1));
      ba = ($urandom_range(0, 4) == 0) ? wa : 5'($urandom_range(0, NREG - 1));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, wa, $urandom,
           a1, a2, $urandom_range(0, 2) == 0, ba);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
